// File: rtl/step_sequencer_multi_if.sv
// Command channel for step_sequencer_multi.
// Ports: valid/ready handshake plus chan, dir, mode, period, steps, hold.
interface step_sequencer_multi_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16,
  parameter int CNT_W    = 16
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CW-1:0]    cmd_chan;
  logic             cmd_dir;
  logic [1:0]       cmd_mode;
  logic [DIV_W-1:0] cmd_period;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_hold;

  modport master (
    output cmd_valid, cmd_chan, cmd_dir, cmd_mode,
    output cmd_period, cmd_steps, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_chan, cmd_dir, cmd_mode,
    input  cmd_period, cmd_steps, cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/step_sequencer_multi.sv
// Multi-channel stepper motor sequencer with per-channel divider.
// Ports: clk, reset (sync, high), cmd (slave), stop, busy, done,
// ax/ay/bx/by registered coil drives (bit c = channel c).
module step_sequencer_multi #(
  parameter int                  CHANNELS = 4,
  parameter int                  DIV_W    = 16,
  parameter int                  CNT_W    = 16,
  parameter logic [CHANNELS-1:0] OUT_INV  = {CHANNELS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  step_sequencer_multi_if.slave cmd,
  input  logic [CHANNELS-1:0]  stop,
  output logic [CHANNELS-1:0]  busy,
  output logic [CHANNELS-1:0]  done,
  output logic [CHANNELS-1:0]  ax,
  output logic [CHANNELS-1:0]  ay,
  output logic [CHANNELS-1:0]  bx,
  output logic [CHANNELS-1:0]  by
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {OFF, HOLD, RUN} st_t;

  function automatic logic [3:0] coil_tbl(input logic [2:0] i);
    logic [3:0] r;
    unique case (i)
      3'd0: r = 4'b1000;
      3'd1: r = 4'b1010;
      3'd2: r = 4'b0010;
      3'd3: r = 4'b0110;
      3'd4: r = 4'b0100;
      3'd5: r = 4'b0101;
      3'd6: r = 4'b0001;
      3'd7: r = 4'b1001;
    endcase
    return r;
  endfunction

  // Out-of-range channel numbers match nothing and stay not-ready.
  logic rdy;
  always_comb begin
    rdy = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      if (cmd.cmd_chan == CW'(c))
        rdy = !busy[c] && !stop[c];
  end
  assign cmd.cmd_ready = rdy;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    st_t              st, n_st;
    logic [2:0]       idx, n_idx, stp;
    logic [DIV_W-1:0] div, n_div, per, n_per;
    logic [CNT_W-1:0] rem, n_rem;
    logic [1:0]       mode, n_mode;
    logic [3:0]       coil, n_coil;
    logic             dir, n_dir, hold, n_hold;
    logic             done_q, n_done, acc, odd;

    assign acc = cmd.cmd_valid && cmd.cmd_ready &&
                 (cmd.cmd_chan == CW'(c));

    // Full (and 11) rests on odd phases, wave on even ones;
    // a parity miss costs one half step before the double steps.
    assign odd = (mode != 2'b00);
    assign stp = (mode == 2'b10 || idx[0] != odd) ? 3'd1 : 3'd2;

    always_comb begin
      n_st   = st;
      n_idx  = idx;
      n_div  = div;
      n_rem  = rem;
      n_per  = per;
      n_dir  = dir;
      n_mode = mode;
      n_hold = hold;
      n_done = 1'b0;
      unique case (st)
        RUN: begin
          if (stop[c]) begin
            n_st   = OFF;
            n_done = 1'b1;
          end else if (div != '0) begin
            n_div = div - DIV_W'(1);
          end else if (rem != '0) begin
            n_idx = dir ? idx + stp : idx - stp;
            n_rem = rem - CNT_W'(1);
            n_div = per;
          end else begin
            // settle period after the last step has elapsed
            n_st   = hold ? HOLD : OFF;
            n_done = 1'b1;
          end
        end
        default: begin
          if (acc) begin
            n_per  = (cmd.cmd_period == '0) ? '0 :
                     cmd.cmd_period - DIV_W'(1);
            n_dir  = cmd.cmd_dir;
            n_mode = cmd.cmd_mode;
            n_hold = cmd.cmd_hold;
            if (cmd.cmd_steps == '0) begin
              n_st   = cmd.cmd_hold ? HOLD : OFF;
              n_done = 1'b1;
            end else begin
              n_st  = RUN;
              n_rem = cmd.cmd_steps;
              n_div = n_per;
            end
          end else if (stop[c]) begin
            n_st = OFF;
          end
        end
      endcase
      n_coil = (n_st == OFF) ? 4'b0000 : coil_tbl(n_idx);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st     <= OFF;
        idx    <= '0;
        div    <= '0;
        rem    <= '0;
        per    <= '0;
        dir    <= 1'b0;
        mode   <= 2'b00;
        hold   <= 1'b0;
        done_q <= 1'b0;
        coil   <= {4{OUT_INV[c]}};
      end else begin
        st     <= n_st;
        idx    <= n_idx;
        div    <= n_div;
        rem    <= n_rem;
        per    <= n_per;
        dir    <= n_dir;
        mode   <= n_mode;
        hold   <= n_hold;
        done_q <= n_done;
        coil   <= n_coil ^ {4{OUT_INV[c]}};
      end
    end

    assign busy[c] = (st == RUN);
    assign done[c] = done_q;
    assign {ax[c], ay[c], bx[c], by[c]} = coil;
  end
endmodule

// File: tb/tb_step_sequencer_multi.sv
// Scoreboard bench for step_sequencer_multi.
// Stimulus pushes timed expectations; a negedge monitor checks them.
module tb_step_sequencer_multi;
  localparam int CH = 4;
  localparam logic [CH-1:0] INV = 4'b0001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CH-1:0] stop = '0;
  logic [CH-1:0] busy, done, ax, ay, bx, by;
  logic [CH-1:0] inv_v = INV;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int cyc;
    int ch;
    int kind;
    logic [3:0] val;
  } exp_t;
  typedef struct {
    int cyc;
    int ch;
  } dn_t;

  exp_t exp_q[$];
  dn_t  done_q[$];

  step_sequencer_multi_if #(
    .CHANNELS(CH), .DIV_W(16), .CNT_W(16)
  ) cif ();

  step_sequencer_multi #(
    .CHANNELS(CH), .DIV_W(16), .CNT_W(16),
    .OUT_INV(INV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd(cif),
    .stop(stop),
    .busy(busy),
    .done(done),
    .ax(ax),
    .ay(ay),
    .bx(bx),
    .by(by)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] coils(input int c);
    return {ax[c], ay[c], bx[c], by[c]};
  endfunction

  task automatic chk(input string nm, input int c,
                     input logic [3:0] got,
                     input logic [3:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s ch%0d cyc%0d got %b want %b",
               nm, c, cyc, got, want);
    end
  endtask

  task automatic ec(input int c, input int t,
                    input logic [3:0] raw);
    exp_q.push_back('{t, c, 0, raw});
  endtask

  task automatic eb(input int c, input int t, input logic b);
    exp_q.push_back('{t, c, 1, {3'b000, b}});
  endtask

  task automatic ed(input int c, input int t);
    done_q.push_back('{t, c});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Returns just after the accepting edge; t = accept cycle.
  task automatic send(input int c, input logic d,
                      input logic [1:0] m, input int p,
                      input int n, input logic h,
                      output int t);
    int k;
    k = 0;
    cif.cmd_valid  = 1'b1;
    cif.cmd_chan   = 2'(c);
    cif.cmd_dir    = d;
    cif.cmd_mode   = m;
    cif.cmd_period = 16'(p);
    cif.cmd_steps  = 16'(n);
    cif.cmd_hold   = h;
    #1;
    while (!cif.cmd_ready && k < 50) begin
      tick(1);
      k++;
    end
    if (!cif.cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout ch%0d cyc%0d got 0 want 1",
               c, cyc);
    end
    t = cyc;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL expired ch%0d cyc%0d got none want %b",
                 exp_q[i].ch, exp_q[i].cyc, exp_q[i].val);
        exp_q.delete(i);
      end else if (exp_q[i].cyc == cyc) begin
        if (exp_q[i].kind == 0)
          chk("coil", exp_q[i].ch, coils(exp_q[i].ch),
              exp_q[i].val ^ {4{inv_v[exp_q[i].ch]}});
        else
          chk("busy", exp_q[i].ch,
              {3'b000, busy[exp_q[i].ch]}, exp_q[i].val);
        exp_q.delete(i);
      end
    end
    for (int c = 0; c < CH; c++) begin
      logic want;
      want = 1'b0;
      for (int i = done_q.size() - 1; i >= 0; i--) begin
        if (done_q[i].cyc == cyc && done_q[i].ch == c) begin
          want = 1'b1;
          done_q.delete(i);
        end
      end
      chk("done", c, {3'b000, done[c]}, {3'b000, want});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc%0d got running want finished",
             cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, s, r;
    cif.cmd_valid  = 1'b0;
    cif.cmd_chan   = '0;
    cif.cmd_dir    = 1'b0;
    cif.cmd_mode   = 2'b00;
    cif.cmd_period = '0;
    cif.cmd_steps  = '0;
    cif.cmd_hold   = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 0, {1'b0, busy[2:0]}, 4'b0000);
    for (int c = 0; c < CH; c++)
      chk("rst_coil", c, coils(c), {4{inv_v[c]}});
    tick(1);
    reset = 1'b0;
    tick(2);

    // ch0 half fwd P=3 N=4
    send(0, 1'b1, 2'b10, 3, 4, 1'b0, t);
    ec(0, t + 1, 4'b1000);
    ec(0, t + 4, 4'b1010);
    ec(0, t + 7, 4'b0010);
    ec(0, t + 10, 4'b0110);
    ec(0, t + 13, 4'b0100);
    ec(0, t + 16, 4'b0000);
    eb(0, t + 1, 1'b1);
    eb(0, t + 15, 1'b1);
    eb(0, t + 16, 1'b0);
    ed(0, t + 16);

    // ch1 full rev P=0 N=3 hold
    send(1, 1'b0, 2'b01, 0, 3, 1'b1, t);
    ec(1, t + 1, 4'b1000);
    ec(1, t + 2, 4'b1001);
    ec(1, t + 3, 4'b0101);
    ec(1, t + 4, 4'b0110);
    ec(1, t + 5, 4'b0110);
    ec(1, t + 8, 4'b0110);
    eb(1, t + 4, 1'b1);
    eb(1, t + 5, 1'b0);
    ed(1, t + 5);

    // ch2 to index 1, then wave fwd P=2 N=2
    send(2, 1'b1, 2'b10, 1, 1, 1'b0, t);
    ec(2, t + 1, 4'b1000);
    ec(2, t + 2, 4'b1010);
    ec(2, t + 3, 4'b0000);
    ed(2, t + 3);
    send(2, 1'b1, 2'b00, 2, 2, 1'b0, t);
    ec(2, t + 1, 4'b1010);
    ec(2, t + 3, 4'b0010);
    ec(2, t + 5, 4'b0100);
    ec(2, t + 7, 4'b0000);
    ed(2, t + 7);

    // ch3 timed to complete alongside ch2
    send(3, 1'b1, 2'b10, 1, 4, 1'b1, t2);
    ec(3, t2 + 1, 4'b1000);
    ec(3, t2 + 2, 4'b1010);
    ec(3, t2 + 3, 4'b0010);
    ec(3, t2 + 4, 4'b0110);
    ec(3, t2 + 5, 4'b0100);
    ec(3, t2 + 9, 4'b0100);
    ed(3, t2 + 6);
    tick(20);

    // stop ch0 mid-run; ch1 still accepts
    send(0, 1'b1, 2'b10, 5, 10, 1'b0, t);
    ec(0, t + 1, 4'b0100);
    eb(0, t + 1, 1'b1);
    tick(1);
    stop[0] = 1'b1;
    s = cyc;
    ed(0, s + 1);
    eb(0, s + 1, 1'b0);
    ec(0, s + 1, 4'b0000);
    tick(1);
    cif.cmd_valid = 1'b1;
    cif.cmd_chan  = 2'd0;
    cif.cmd_steps = 16'd1;
    #1;
    chk("ready_stop", 0, {3'b000, cif.cmd_ready}, 4'b0000);
    cif.cmd_valid = 1'b0;
    send(1, 1'b0, 2'b10, 1, 1, 1'b0, t);
    ec(1, t + 1, 4'b0110);
    ec(1, t + 2, 4'b0010);
    ec(1, t + 3, 4'b0000);
    ec(0, t + 3, 4'b0000);
    eb(1, t + 1, 1'b1);
    ed(1, t + 3);
    stop[0] = 1'b0;
    tick(5);

    // ch0 N=0 hold: index 4 kept through stop
    send(0, 1'b1, 2'b10, 7, 0, 1'b1, t);
    ed(0, t + 1);
    ec(0, t + 1, 4'b0100);
    eb(0, t + 1, 1'b0);
    ec(0, t + 3, 4'b0100);
    tick(3);

    // reset during run: no done, everything off
    send(0, 1'b1, 2'b10, 2, 5, 1'b0, t);
    ec(0, t + 1, 4'b0100);
    eb(0, t + 1, 1'b1);
    ec(0, t + 3, 4'b0101);
    tick(3);
    reset = 1'b1;
    r = cyc;
    eb(0, r + 1, 1'b0);
    ec(0, r + 1, 4'b0000);
    ec(3, r + 1, 4'b0000);
    tick(1);
    reset = 1'b0;
    tick(2);

    // index cleared by reset
    send(0, 1'b1, 2'b10, 4, 0, 1'b1, t);
    ed(0, t + 1);
    ec(0, t + 1, 4'b1000);
    eb(0, t + 1, 1'b0);
    tick(5);

    tests++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      fails++;
      $display("FAIL leftover got %0d want 0",
               exp_q.size() + done_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/step_sequencer_multi.md
STEP_SEQUENCER_MULTI -- requirements
Module: step_sequencer_multi

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4: number of independent stepper channels (1..8).
REQ-002 SHALL provide parameter DIV_W, default 16: step-period counter width.
REQ-003 SHALL provide parameter CNT_W, default 16: step-count width.
REQ-004 SHALL provide parameter OUT_INV, default {CHANNELS{1'b0}}: per-channel bitmask; bit c set inverts all four coil outputs of channel c.
REQ-005 SHALL provide clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-007 SHALL provide cmd_valid  input  1  command offered.
REQ-008 SHALL provide cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-009 SHALL provide cmd_chan  input  max(1,clog2(CHANNELS))  target channel; values >= CHANNELS: never ready.
REQ-010 SHALL provide cmd_dir  input  1  1 = forward (index +), 0 = reverse.
REQ-011 SHALL provide cmd_mode  input  2  00 wave, 01 full, 10 half, 11 treated as full.
REQ-012 SHALL provide cmd_period  input  DIV_W  clocks per step; 0 treated as 1.
REQ-013 SHALL provide cmd_steps  input  CNT_W  steps to execute.
REQ-014 SHALL provide cmd_hold  input  1  keep coils energised after completion.
REQ-015 SHALL provide stop  input  CHANNELS  per-channel abort.
REQ-016 SHALL provide busy  output  CHANNELS  channel in RUN.
REQ-017 SHALL provide done  output  CHANNELS  one-cycle completion/abort pulse.
REQ-018 SHALL provide ax, ay, bx, by  output  CHANNELS each  registered coil drives, bit c = channel c.

Function
REQ-019 Each channel SHALL hold a 3-bit phase index, wrapping mod 8; (AX,AY,BX,BY) per index: 0=1000, 1=1010, 2=0010, 3=0110, 4=0100, 5=0101, 6=0001, 7=1001.
REQ-020 Each channel SHALL have states OFF (coils 0000), HOLD (coils = table[index]), RUN (coils = table[index]); OUT_INV applied after the table in all states.
REQ-021 cmd_ready SHALL equal !busy[cmd_chan] & !stop[cmd_chan] & (cmd_chan < CHANNELS), combinational.
REQ-022 On acceptance at cycle T with steps N>0: RUN, busy=1 and coils=table[index] from T+1; divider loaded P-1 (P = max(period,1)).
REQ-023 In RUN, step k (k=1..N) SHALL update coils at cycle T+1+k*P; completion at T+1+(N+1)*P (one settle period after final step).
REQ-024 Step size: half = ±1; full = ±2 landing on odd indices; wave = ±2 landing on even; if index parity mismatches mode, first step SHALL be ±1 to reach correct parity, then ±2.
REQ-025 At completion cycle: busy=0, done=1 for exactly that cycle, state HOLD if cmd_hold else OFF (coils change same cycle).
REQ-026 N=0: no motion, busy never asserts, done=1 at T+1, state HOLD if cmd_hold else OFF.
REQ-027 stop[c] in RUN: at next cycle state OFF, busy=0, done=1 one cycle, index retained; stop in HOLD: OFF, no done; stop in OFF: no effect.
REQ-028 Channels SHALL run fully independently; simultaneous completions SHALL assert multiple done bits the same cycle.
REQ-029 Index SHALL persist across commands and OFF; only reset clears it.

Reset
REQ-030 While reset=1 (sync): all channels OFF, index 0, divider and step counters 0, busy=0, done=0, coil outputs = OUT_INV pattern (0 uninverted, 1 inverted); reset mid-RUN aborts without done.

Verification
REQ-031 Ch0 half, fwd, P=3, N=4, index 0, accept T=10 -> coils 1000@11, 1010@14, 0010@17, 0110@20, 0100@23; done[0]=1, busy[0]=0 @26; hold=0 -> 0000 @26.
REQ-032 Ch1 full, rev, P=0, N=3, index 0 -> steps each cycle: index 7, 5, 3; done @T+5; hold=1 -> coils 0110 retained.
REQ-033 Ch2 wave, fwd, P=2, N=2, index 1 -> index 2 @T+3, 4 @T+5; done @T+7.
REQ-034 Ch0 RUN, stop[0] at cycle S -> OFF, busy 0, done 1 at S+1; new command to ch0 with stop[0]=1 -> cmd_ready=0; ch1 command accepted meanwhile.
REQ-035 OUT_INV=4'b0001, reset -> ax..by[0]=1, others 0; N=0 with hold=1 -> done @T+1, ch0 coils ~1000; reset mid-RUN -> busy 0, no done, index 0.
